axi4_lite_reg_bank: RTL
=======================

// Module: axi4_lite_reg_bank
// PURPOSE
//  AXI4-Lite subordinate plus register bank; the endpoint the AXI VIP master drives.
//  Accepts single-beat writes and reads and stores data in NUM_REGS 32-bit registers.
//  Exports register contents and per-register write pulses to user logic.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4   byte-address width; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]
//  NUM_REGS            4   implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2)
// PORTS
//  ACLK           in   1       single clock; all logic on rising edge
//  ARESET         in   1       synchronous, active-high reset
//  S_AXI_AWADDR   in   AW      write address
//  S_AXI_AWPROT   in   3       ignored
//  S_AXI_AWVALID  in   1       / S_AXI_AWREADY out 1: write-address handshake
//  S_AXI_WDATA    in   32      write data
//  S_AXI_WSTRB    in   4       byte enables
//  S_AXI_WVALID   in   1       / S_AXI_WREADY out 1: write-data handshake
//  S_AXI_BRESP    out  2       write response
//  S_AXI_BVALID   out  1       / S_AXI_BREADY in 1: write-response handshake
//  S_AXI_ARADDR   in   AW      read address
//  S_AXI_ARPROT   in   3       ignored
//  S_AXI_ARVALID  in   1       / S_AXI_ARREADY out 1: read-address handshake
//  S_AXI_RDATA    out  32      read data
//  S_AXI_RRESP    out  2       read response
//  S_AXI_RVALID   out  1       / S_AXI_RREADY in 1: read-data handshake
//  reg_out        out  32*NUM_REGS  register contents; reg i at [32*i+:32]
//  reg_wr_pulse   out  NUM_REGS     1-cycle pulse in the cycle after reg i is written
// BEHAVIOUR
//  Reset (ARESET=1 at edge): all registers 0; AWREADY/WREADY/ARREADY/BVALID/RVALID 0;
//   RDATA 0; BRESP/RRESP 00; reg_wr_pulse 0. Readys rise 1 cycle after ARESET drops.
//  Reset mid-transaction aborts it; no response is issued afterwards.
//  Write FSM: W_IDLE -> W_RESP -> W_IDLE.
//   AW and W accepted independently in any order; each latched in a holding reg.
//   AWREADY=0 while an address is held or BVALID=1; WREADY likewise for data.
//   When both held: commit the write, set BVALID next cycle (W_RESP), clear holds.
//   Same-cycle AW+W handshake: BVALID asserted the following cycle (1-cycle latency).
//   BVALID/BRESP held stable until BREADY; one outstanding write max.
//   WSTRB[k]=1 updates byte k only; WSTRB=0000 is a legal no-op that returns OKAY.
//  Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   ARREADY=1 in R_IDLE; after handshake, RDATA/RRESP/RVALID registered next cycle.
//   RVALID/RDATA held until RREADY; ARREADY=0 while RVALID=1; one outstanding read.
//  Simultaneous read and write commit to same register: read returns pre-write value.
//  Address bits [1:0] ignored (no unaligned support). AWPROT/ARPROT unused.
//  Out-of-range: word index >= NUM_REGS; see CONFIGURATION for response.
//  reg_wr_pulse fires only on in-range commits, even when WSTRB=0000.
// CONFIGURATION
//  AXI4_LITE_REG_BANK_SLVERR_EN defined: out-of-range write -> no state change,
//   BRESP=10 (SLVERR); out-of-range read -> RDATA=0, RRESP=10.
//  Not defined: out-of-range writes silently dropped with BRESP=00; reads return
//   RDATA=0 with RRESP=00. In-range accesses always respond 00 (OKAY).
// TESTING
//  Write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC; read back -> same data, RRESP=00.
//  AW at cycle n, W at n+3 (addr 0x4, data 0xDEADBEEF) -> BVALID at n+4, reg1=0xDEADBEEF.
//  reg0=0x11223344, write 0xAABBCCDD WSTRB=0101 to 0x0 -> reg0=0x11BB33DD.
//  BREADY held low 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY/WREADY stay 0.
//  NUM_REGS=3, read 0xC -> RDATA=0; RRESP=10 with _SLVERR_EN, 00 without.
//  Assert ARESET while BVALID=1 -> BVALID=0 next cycle, all registers 0.

Source files
------------

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite subordinate fronting NUM_REGS 32-bit registers with per-register write pulses.
// Define AXI4_LITE_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_reg_bank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IdxW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned StrbW = DW / 8;
  localparam logic [1:0]  RespOkay = 2'b00;
`ifdef AXI4_LITE_REG_BANK_SLVERR_EN
  localparam logic [1:0]  RespOor  = 2'b10;
`else
  localparam logic [1:0]  RespOor  = 2'b00;
`endif

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  logic             r_awready, r_wready, r_arready;
  logic             r_aw_held, r_w_held;
  logic [IdxW-1:0]  r_aw_idx;
  logic [DW-1:0]    r_w_data;
  logic [StrbW-1:0] r_w_strb;
  logic [1:0]       r_bresp, r_rresp;
  logic [DW-1:0]    r_rdata;
  logic [DW-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic             w_aw_held_nxt, w_w_held_nxt;
  logic [IdxW-1:0]  w_wr_idx, w_ar_idx;
  logic [DW-1:0]    w_wr_data, w_rd_word;
  logic [StrbW-1:0] w_wr_strb;
  logic             w_wr_in_range, w_ar_in_range;
  logic             w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID & r_wready;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;

  // A channel arriving this cycle is used directly so a same-cycle AW+W commits at once.
  assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr_data = r_w_held ? r_w_data : S_AXI_WDATA;
  assign w_wr_strb = r_w_held ? r_w_strb : S_AXI_WSTRB;
  assign w_commit  = (r_wstate == WIdle) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_wr_in_range = 32'(w_wr_idx) < NUM_REGS;

  assign w_aw_held_nxt = ~w_commit & (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = ~w_commit & (r_w_held | w_w_hs);

  assign w_ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_in_range = 32'(w_ar_idx) < NUM_REGS;

  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      WIdle: if (w_commit) w_wstate_nxt = WResp;
      WResp: if (S_AXI_BREADY) w_wstate_nxt = WIdle;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      RIdle: if (w_ar_hs) w_rstate_nxt = RData;
      RData: if (S_AXI_RREADY) w_rstate_nxt = RIdle;
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(w_ar_idx) == i) w_rd_word = r_regs[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate   <= WIdle;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bresp    <= RespOkay;
      r_wr_pulse <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      r_awready <= (w_wstate_nxt == WIdle) & ~w_aw_held_nxt;
      r_wready  <= (w_wstate_nxt == WIdle) & ~w_w_held_nxt;
      if (w_commit) r_bresp <= w_wr_in_range ? RespOkay : RespOor;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit & (32'(w_wr_idx) == i);
      end
    end
  end

  // Out-of-range commits match no index, so they leave every register untouched.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(w_wr_idx) == i) begin
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (w_wr_strb[b]) r_regs[i][8*b+:8] <= w_wr_data[8*b+:8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= RIdle;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RespOkay;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == RIdle);
      if (w_ar_hs) begin
        r_rdata <= w_ar_in_range ? w_rd_word : '0;
        r_rresp <= w_ar_in_range ? RespOkay : RespOor;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[DW*g+:DW] = r_regs[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = (r_wstate == WResp);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = (r_rstate == RData);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule
